// File: rtl/pulse_gen.sv
// pulse_gen: turns a single-cycle start trigger into a train of level pulses
// with run-time high/low widths and pulse count.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : single-cycle trigger, accepted only while idle and stop=0
//   stop       : single-cycle request to end the train after the current high phase
//   high_len   : high-phase length in cycles (0 treated as 1), sampled on start
//   low_len    : low-phase length in cycles (0 treated as 1), sampled on start
//   pulse_cnt  : number of pulses, 0 = run until stop, sampled on start
//   out        : generated pulse train (registered)
//   busy       : train in progress (registered)
//   done       : one-cycle strobe in the first idle cycle after a train ends
module pulse_gen #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [CNT_W-1:0] pulse_cnt,
   output logic             out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] l_q, l_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] pidx_q, pidx_d;
   logic             stop_pend_q, stop_pend_d;
   logic             out_d, busy_d, done_d;
   logic             last_pulse;

   // Only a nonzero count can run out; N=0 runs until stop.
   assign last_pulse = (n_q != '0) && (pidx_q == n_q);

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         h_q         <= '0;
         l_q         <= '0;
         n_q         <= '0;
         phase_q     <= '0;
         pidx_q      <= '0;
         stop_pend_q <= 1'b0;
         out         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         l_q         <= l_d;
         n_q         <= n_d;
         phase_q     <= phase_d;
         pidx_q      <= pidx_d;
         stop_pend_q <= stop_pend_d;
         out         <= out_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      l_d         = l_q;
      n_d         = n_q;
      phase_d     = phase_q;
      pidx_d      = pidx_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d     = HIGH;
               h_d         = (high_len == '0) ? CNT_W'(1) : high_len;
               l_d         = (low_len == '0) ? CNT_W'(1) : low_len;
               n_d         = pulse_cnt;
               phase_d     = CNT_W'(1);
               pidx_d      = CNT_W'(1);
               stop_pend_d = 1'b0;
            end
         end

         HIGH: begin
            stop_pend_d = stop_pend_q | stop;
            if (phase_q == h_q) begin
               // A stop arriving in the final high cycle still ends here
               if (last_pulse || stop_pend_q || stop) begin
                  state_d     = IDLE;
                  phase_d     = '0;
                  stop_pend_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  state_d = LOW;
                  phase_d = CNT_W'(1);
               end
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end

         LOW: begin
            if (stop || stop_pend_q) begin
               state_d     = IDLE;
               phase_d     = '0;
               stop_pend_d = 1'b0;
               done_d      = 1'b1;
            end else if (phase_q == l_q) begin
               state_d = HIGH;
               phase_d = CNT_W'(1);
               pidx_d  = pidx_q + CNT_W'(1);
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      out_d  = (state_d == HIGH);
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed and randomized checks of pulse_gen against an
// arithmetic reference model (offset within the train, period H+L, end offset).
module tb_pulse_gen;

   localparam int unsigned CNT_W = 16;
   localparam longint      NEVER = 64'sh7FFF_FFFF_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] pulse_cnt;
   logic             out;
   logic             busy;
   logic             done;

   pulse_gen #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .high_len  (high_len),
      .low_len   (low_len),
      .pulse_cnt (pulse_cnt),
      .out       (out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: train described by offset from first high cycle
   bit     m_busy = 1'b0;
   bit     m_done = 1'b0;
   longint m_off  = 0;
   longint m_end  = NEVER;
   longint m_h    = 1;
   longint m_l    = 1;
   bit     m_prev_out = 1'b0;
   int     m_rise = 0;
   int     m_done_cnt = 0;

   // Observed statistics
   logic   prev_out = 1'b0;
   int     rise_cnt = 0;
   int     busy_cyc = 0;
   int     done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_out();
      return m_busy && ((m_off % (m_h + m_l)) < m_h);
   endfunction

   // Called at a negedge: check this cycle, drive inputs, advance model one cycle.
   task automatic step(input logic s, input logic p, input int hl, input int ll, input int pc);
      longint per;
      longint stop_end;
      bit     exp_out;
      per     = m_h + m_l;
      exp_out = model_out();
      check("out", out, exp_out);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (out && !prev_out) rise_cnt++;
      prev_out = out;
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (exp_out && !m_prev_out) m_rise++;
      m_prev_out = exp_out;

      start     = s;
      stop      = p;
      high_len  = CNT_W'(hl);
      low_len   = CNT_W'(ll);
      pulse_cnt = CNT_W'(pc);

      if (m_busy) begin
         if (p) begin
            if ((m_off % per) < m_h) stop_end = (m_off / per) * per + m_h;
            else                     stop_end = m_off + 1;
            if (stop_end < m_end) m_end = stop_end;
         end
         m_off++;
         m_done = 1'b0;
         if (m_off == m_end) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_done_cnt++;
         end
      end else begin
         m_done = 1'b0;
         if (s && !p) begin
            m_h    = (hl == 0) ? 1 : longint'(hl);
            m_l    = (ll == 0) ? 1 : longint'(ll);
            m_off  = 0;
            m_end  = (pc == 0) ? NEVER : longint'(pc) * m_h + longint'(pc - 1) * m_l;
            m_busy = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Idle cycles with junk on the length inputs to show they are ignored mid-train.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)));
   endtask

   task automatic clear_stats();
      rise_cnt = 0;
      busy_cyc = 0;
      done_cnt = 0;
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_off  = 0;
      m_end  = NEVER;
      m_h    = 1;
      m_l    = 1;
      m_prev_out = 1'b0;
      prev_out   = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      high_len = '0; low_len = '0; pulse_cnt = '0;

      // Reset values held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out", out, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
      end
      rst = 1'b0;
      model_reset();
      idle(2);

      // Basic train 3/2/4
      clear_stats();
      step(1'b1, 1'b0, 3, 2, 4);
      idle(22);
      check("basic_rises", rise_cnt, 4);
      check("basic_busy", busy_cyc, 18);
      check("basic_done", done_cnt, 1);

      // Zero lengths clamp to 1
      clear_stats();
      step(1'b1, 1'b0, 0, 0, 3);
      idle(8);
      check("clamp_rises", rise_cnt, 3);
      check("clamp_busy", busy_cyc, 5);
      check("clamp_done", done_cnt, 1);

      // Stop in 2nd cycle of the 2nd high phase
      clear_stats();
      step(1'b1, 1'b0, 5, 5, 0);
      idle(11);
      step(1'b0, 1'b1, 5, 5, 0);
      idle(15);
      check("stophi_rises", rise_cnt, 2);
      check("stophi_busy", busy_cyc, 15);
      check("stophi_done", done_cnt, 1);

      // Stop during a low phase
      clear_stats();
      step(1'b1, 1'b0, 5, 5, 0);
      idle(7);
      step(1'b0, 1'b1, 5, 5, 0);
      idle(6);
      check("stoplo_rises", rise_cnt, 1);
      check("stoplo_busy", busy_cyc, 8);
      check("stoplo_done", done_cnt, 1);

      // Stop together with start in idle: start loses
      clear_stats();
      step(1'b1, 1'b1, 3, 3, 2);
      idle(4);
      check("stopwin_busy", busy_cyc, 0);

      // Start while busy is ignored
      clear_stats();
      step(1'b1, 1'b0, 3, 2, 2);
      step(1'b0, 1'b0, 3, 2, 2);
      step(1'b1, 1'b0, 7, 7, 5);
      guard = 0;
      while (!m_done && guard < 100) begin
         idle(1);
         guard++;
      end
      check("busy_ignore_guard", (guard < 100), 1'b1);
      check("busy_ignore_busy", busy_cyc, 8);
      check("busy_ignore_rises", rise_cnt, 2);

      // Start in the done cycle is accepted
      check("done_cycle", done, 1'b1);
      step(1'b1, 1'b0, 2, 1, 1);
      check("restart_out", out, 1'b1);
      check("restart_busy", busy, 1'b1);
      idle(4);

      // Asynchronous reset mid-high, no done afterwards
      step(1'b1, 1'b0, 6, 2, 0);
      idle(2);
      #2 rst = 1'b1;
      #1;
      check("arst_out", out, 1'b0);
      check("arst_busy", busy, 1'b0);
      @(negedge clk);
      check("arst_done", done, 1'b0);
      rst = 1'b0;
      model_reset();
      idle(1);
      check("arst_done_after", done, 1'b0);
      idle(1);

      // Randomized start/stop/lengths
      m_rise = 0; m_done_cnt = 0;
      clear_stats();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 8) == 0, ($urandom % 40) == 0,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 5)));
      end
      idle(1);
      check("rand_rises", rise_cnt, m_rise);
      check("rand_done", done_cnt, m_done_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
Programmable pulse-train generator. It is the inverse of the edge detector: it turns a single-cycle trigger pulse into a train of level pulses with run-time high/low widths and count. Used in benches and in RTL to drive strobes, test stimulus and stretched enables from single-cycle events. All outputs are registered.

Parameters:
CNT_W, 16, width of the high_len, low_len and pulse_cnt inputs and of the internal counters

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle trigger; accepted only while idle
stop  input  1  single-cycle request to terminate the train gracefully
high_len  input  CNT_W  high-phase length in clk cycles; sampled on accepted start
low_len  input  CNT_W  low-phase length in clk cycles; sampled on accepted start
pulse_cnt  input  CNT_W  number of pulses; 0 = run until stop; sampled on accepted start
out  output  1  generated pulse train
busy  output  1  high while a train is in progress
done  output  1  one-cycle strobe when a train terminates

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst). While rst=1: out=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-train aborts the train immediately, with no done strobe.
- States:
  - IDLE: out=0, busy=0.
  - HIGH: out=1, busy=1.
  - LOW: out=0, busy=1.
- Start acceptance: start=1 in IDLE (and stop=0) at edge t latches H=max(high_len,1), L=max(low_len,1), N=pulse_cnt, then enters HIGH. out=1 and busy=1 are visible from cycle t+1, so latency is 1 cycle.
- Start is ignored while busy. It is also ignored in IDLE when stop=1 in the same cycle (stop wins).
- Input changes after acceptance have no effect on the running train.
- HIGH: lasts exactly H cycles. At the end of the phase:
  - if this was pulse N (N≠0), or a stop is pending → IDLE;
  - otherwise → LOW.
- LOW: lasts exactly L cycles, then → HIGH with the pulse counter incremented.
- The trailing low phase after the last pulse is not generated. out falls and busy falls on the same edge.
- Pulse period is H+L cycles. Total busy time for finite N is N·H+(N−1)·L cycles.
- stop handling:
  - stop=1 while busy sets stop_pending.
  - In HIGH, the current high phase completes in full (no runt pulse), then → IDLE.
  - In LOW, → IDLE on the next edge; out is already 0.
  - stop in IDLE has no effect.
- done: 1-cycle strobe in the first cycle after busy falls, on both normal completion and stop. It is never asserted after reset.
- N=0: infinite train; it terminates only via stop or rst.
- Counter widths: pulse counter is CNT_W bits and compares to N. The phase counter counts 1..H or 1..L, so there is no wrap for any CNT_W-bit value. Max lengths are 2^CNT_W−1.
- A new start is accepted in the same cycle that done is high, because the block is already IDLE. That train's first out=1 appears on the next edge.

Test Plan:
- Reset values: hold rst=1 for 3 cycles → out=0, busy=0, done=0. Assert rst async mid-HIGH of a train → out, busy drop without waiting for clk; no done.
- Basic train: start with high_len=3, low_len=2, pulse_cnt=4 → out pattern 111 00 111 00 111 00 111; busy high 18 cycles; done 1 cycle after; exactly 4 rising edges on out.
- Zero-length clamp: high_len=0, low_len=0, pulse_cnt=3 → out 1 0 1 0 1 (H=L=1); busy 5 cycles.
- Stop in HIGH: high_len=5, low_len=5, pulse_cnt=0; pulse stop at cycle 2 of the 2nd high phase → that phase stays high 5 cycles total, then IDLE, done strobe, no 3rd pulse. Stop in LOW → IDLE next edge.
- Start while busy: pulse start again mid-train with different lengths → ignored; the train keeps its original H/L/N. Start in the done cycle → new train accepted, out=1 next edge.
- Random: drive start/stop from c_rand bits, lengths from random 4-bit values → scoreboard checks rising-edge count, phase lengths and done count against a reference model.
